// File: rtl/contador_pkg.sv
// Shared types and constants for the BCD millisecond stopwatch.
package contador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs for BCD digits 0-9.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD decade: counts 0-9 on inc, ripples carry out combinationally.
module bcd_digit
    import contador_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        end
    end

    assign carry = inc && (q == BCD_MAX);

endmodule

// File: rtl/contador_ms_bcd.sv
// 4-digit BCD millisecond stopwatch with start/stop/clear FSM and
// multiplexed common-anode 7-segment drive.
module contador_ms_bcd
    import contador_pkg::*;
#(
    parameter bit WRAP    = 1'b1,
    parameter bit SCAN_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        tick_ms,
    input  logic        tick_scan,
    input  logic        btn_ss,
    input  logic        btn_clr,
    output logic [15:0] count_bcd,
    output logic        running,
    output logic        ovf,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    state_t     state, state_next;
    logic       ss_q, clr_q;
    logic       ss_rise, clr_rise;
    logic       at_max, tick_run, inc0, ovf_set;
    logic [3:0] d0, d1, d2, d3;
    logic       c0, c1, c2, c3;
    logic [1:0] idx, idx_next;
    logic [3:0] sel_digit;

    assign ss_rise  = btn_ss  && !ss_q;
    assign clr_rise = btn_clr && !clr_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ss_q    <= 1'b0;
            clr_q   <= 1'b0;
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            ss_q    <= btn_ss;
            clr_q   <= btn_clr;
            state   <= state_next;
            running <= (state_next == RUN);
        end
    end

    always_comb begin
        state_next = state;
        if (clr_rise) begin
            state_next = IDLE;
        end else if (ss_rise) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Counting keys off the registered state, so a start-edge tick is
    // dropped while a stop-edge tick is still counted.
    assign at_max   = (count_bcd == 16'h9999);
    assign tick_run = (state == RUN) && tick_ms && !clr_rise;
    assign inc0     = tick_run && (WRAP || !at_max);
    assign ovf_set  = WRAP ? c3 : (tick_run && at_max);

    bcd_digit u_d0 (.CLK(CLK), .RST(RST), .clr(clr_rise), .inc(inc0), .q(d0), .carry(c0));
    bcd_digit u_d1 (.CLK(CLK), .RST(RST), .clr(clr_rise), .inc(c0),   .q(d1), .carry(c1));
    bcd_digit u_d2 (.CLK(CLK), .RST(RST), .clr(clr_rise), .inc(c1),   .q(d2), .carry(c2));
    bcd_digit u_d3 (.CLK(CLK), .RST(RST), .clr(clr_rise), .inc(c2),   .q(d3), .carry(c3));

    assign count_bcd = {d3, d2, d1, d0};

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ovf <= 1'b0;
        end else if (clr_rise) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end
    end

    assign idx_next = SCAN_EN ? (tick_scan ? idx + 2'd1 : idx) : 2'd0;

    always_comb begin
        sel_digit = d0;
        case (idx_next)
            2'd0: sel_digit = d0;
            2'd1: sel_digit = d1;
            2'd2: sel_digit = d2;
            2'd3: sel_digit = d3;
            default: sel_digit = d0;
        endcase
    end

    // an and seg share one edge so the glyph never lags its anode.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            idx <= 2'd0;
            an  <= 4'b1110;
            seg <= seg_decode(4'd0);
        end else begin
            idx <= idx_next;
            an  <= ~(4'b0001 << idx_next);
            seg <= seg_decode(sel_digit);
        end
    end

endmodule

// File: tb/tb_contador_ms_bcd.sv
// Directed self-checking bench: wrapping and saturating instances share stimulus.
module tb_contador_ms_bcd;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        tick_ms = 1'b0;
    logic        tick_scan = 1'b0;
    logic        btn_ss = 1'b0;
    logic        btn_clr = 1'b0;
    logic [15:0] count_bcd, count_sat;
    logic        running, running_sat;
    logic        ovf, ovf_sat;
    logic [3:0]  an, an_sat;
    logic [6:0]  seg, seg_sat;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    contador_ms_bcd #(.WRAP(1'b1), .SCAN_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST), .tick_ms(tick_ms), .tick_scan(tick_scan),
        .btn_ss(btn_ss), .btn_clr(btn_clr), .count_bcd(count_bcd),
        .running(running), .ovf(ovf), .an(an), .seg(seg)
    );

    contador_ms_bcd #(.WRAP(1'b0), .SCAN_EN(1'b1)) dut_sat (
        .CLK(CLK), .RST(RST), .tick_ms(tick_ms), .tick_scan(tick_scan),
        .btn_ss(btn_ss), .btn_clr(btn_clr), .count_bcd(count_sat),
        .running(running_sat), .ovf(ovf_sat), .an(an_sat), .seg(seg_sat)
    );

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        tick_ms = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        tick_ms = 1'b0;
    endtask

    task automatic press_ss();
        btn_ss = 1'b1;
        cycle();
        btn_ss = 1'b0;
        cycle();
    endtask

    task automatic press_clr();
        btn_clr = 1'b1;
        cycle();
        btn_clr = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        RST = 1'b0;
        cycle();
        cycle();
        RST = 1'b1;
        btn_ss = 1'b0;
        btn_clr = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        RST = 1'b0;
        btn_ss = 1'b1;
        btn_clr = 1'b0;
        cycle();
        btn_ss = 1'b0;
        btn_clr = 1'b1;
        cycle();
        checks++;
        if (count_bcd !== 16'h0000) begin
            failures++; $display("FAIL reset_count got=%h exp=0000", count_bcd);
        end
        checks++;
        if (running !== 1'b0 || ovf !== 1'b0) begin
            failures++; $display("FAIL reset_flags got run=%b ovf=%b exp run=0 ovf=0", running, ovf);
        end
        checks++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            failures++; $display("FAIL reset_display got an=%b seg=%b exp an=1110 seg=1000000", an, seg);
        end
        btn_clr = 1'b0;
        RST = 1'b1;
        cycle();
    endtask

    task automatic test_count();
        press_ss();
        ticks(1234);
        press_ss();
        checks++;
        if (count_bcd !== 16'h1234 || running !== 1'b0) begin
            failures++; $display("FAIL count_1234 got=%h run=%b exp=1234 run=0", count_bcd, running);
        end
        ticks(5);
        checks++;
        if (count_bcd !== 16'h1234) begin
            failures++; $display("FAIL pause_hold got=%h exp=1234", count_bcd);
        end
        press_ss();
        ticks(1);
        checks++;
        if (count_bcd !== 16'h1235 || running !== 1'b1) begin
            failures++; $display("FAIL resume got=%h run=%b exp=1235 run=1", count_bcd, running);
        end
        press_clr();
        checks++;
        if (count_bcd !== 16'h0000 || running !== 1'b0) begin
            failures++; $display("FAIL clear got=%h run=%b exp=0000 run=0", count_bcd, running);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        press_ss();
        ticks(9998);
        checks++;
        if (count_bcd !== 16'h9998 || count_sat !== 16'h9998 || ovf !== 1'b0) begin
            failures++; $display("FAIL preload got=%h sat=%h ovf=%b exp=9998 ovf=0", count_bcd, count_sat, ovf);
        end
        ticks(1);
        checks++;
        if (count_bcd !== 16'h9999 || ovf !== 1'b0 || ovf_sat !== 1'b0) begin
            failures++; $display("FAIL at_9999 got=%h ovf=%b ovf_sat=%b exp=9999 ovf=0", count_bcd, ovf, ovf_sat);
        end
        ticks(1);
        checks++;
        if (count_bcd !== 16'h0000 || ovf !== 1'b1 || running !== 1'b1) begin
            failures++; $display("FAIL wrap got=%h ovf=%b run=%b exp=0000 ovf=1 run=1", count_bcd, ovf, running);
        end
        checks++;
        if (count_sat !== 16'h9999 || ovf_sat !== 1'b1 || running_sat !== 1'b1) begin
            failures++; $display("FAIL saturate got=%h ovf=%b run=%b exp=9999 ovf=1 run=1", count_sat, ovf_sat, running_sat);
        end
        ticks(3);
        checks++;
        if (count_bcd !== 16'h0003 || ovf !== 1'b1 || count_sat !== 16'h9999) begin
            failures++; $display("FAIL post_wrap got=%h ovf=%b sat=%h exp=0003 ovf=1 sat=9999", count_bcd, ovf, count_sat);
        end
    endtask

    task automatic test_clear_priority();
        press_clr();
        checks++;
        if (ovf !== 1'b0 || ovf_sat !== 1'b0) begin
            failures++; $display("FAIL clr_ovf got ovf=%b ovf_sat=%b exp 0", ovf, ovf_sat);
        end
        press_ss();
        ticks(42);
        checks++;
        if (count_bcd !== 16'h0042) begin
            failures++; $display("FAIL count_42 got=%h exp=0042", count_bcd);
        end
        btn_ss = 1'b1;
        btn_clr = 1'b1;
        tick_ms = 1'b1;
        cycle();
        tick_ms = 1'b0;
        checks++;
        if (count_bcd !== 16'h0000 || running !== 1'b0) begin
            failures++; $display("FAIL clr_wins got=%h run=%b exp=0000 run=0", count_bcd, running);
        end
        btn_ss = 1'b0;
        btn_clr = 1'b0;
        cycle();
        btn_ss = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        btn_ss = 1'b0;
        cycle();
        checks++;
        if (running !== 1'b1) begin
            failures++; $display("FAIL held_button got run=%b exp=1", running);
        end
        ticks(2);
        checks++;
        if (count_bcd !== 16'h0002) begin
            failures++; $display("FAIL held_count got=%h exp=0002", count_bcd);
        end
    endtask

    task automatic test_tick_edges();
        press_clr();
        btn_ss = 1'b1;
        tick_ms = 1'b1;
        cycle();
        btn_ss = 1'b0;
        tick_ms = 1'b0;
        cycle();
        checks++;
        if (count_bcd !== 16'h0000 || running !== 1'b1) begin
            failures++; $display("FAIL start_tick got=%h run=%b exp=0000 run=1", count_bcd, running);
        end
        ticks(3);
        btn_ss = 1'b1;
        tick_ms = 1'b1;
        cycle();
        btn_ss = 1'b0;
        tick_ms = 1'b0;
        cycle();
        checks++;
        if (count_bcd !== 16'h0004 || running !== 1'b0) begin
            failures++; $display("FAIL stop_tick got=%h run=%b exp=0004 run=0", count_bcd, running);
        end
    endtask

    task automatic test_display();
        logic [3:0] an_tab [4];
        logic [6:0] seg_tab [4];
        int idx;
        an_tab[0] = 4'b1110; seg_tab[0] = 7'b0011001;
        an_tab[1] = 4'b1101; seg_tab[1] = 7'b0110000;
        an_tab[2] = 4'b1011; seg_tab[2] = 7'b0100100;
        an_tab[3] = 4'b0111; seg_tab[3] = 7'b1111001;
        do_reset();
        press_ss();
        ticks(1234);
        press_ss();
        checks++;
        if (an !== an_tab[0] || seg !== seg_tab[0]) begin
            failures++; $display("FAIL scan_start got an=%b seg=%b exp an=%b seg=%b", an, seg, an_tab[0], seg_tab[0]);
        end
        for (int k = 0; k < 8; k++) begin
            tick_scan = 1'b1;
            cycle();
            tick_scan = 1'b0;
            idx = (k + 1) % 4;
            checks++;
            if (an !== an_tab[idx] || seg !== seg_tab[idx]) begin
                failures++; $display("FAIL scan_%0d got an=%b seg=%b exp an=%b seg=%b", k, an, seg, an_tab[idx], seg_tab[idx]);
            end
            cycle();
            checks++;
            if (an !== an_tab[idx] || seg !== seg_tab[idx]) begin
                failures++; $display("FAIL scan_hold_%0d got an=%b seg=%b exp an=%b seg=%b", k, an, seg, an_tab[idx], seg_tab[idx]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_clear_priority();
        test_tick_edges();
        test_display();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
